// File: rtl/cc_waypoint_bank_loader_pkg.sv
// Shared definitions for the waypoint bank loader.
//  - loader FSM state encoding
//  - default sizing (data width, slot count, select width)
//  - slot packing macro: slot k of a flat bus lives at [k*w +: w]
`define CC_WP_SLOT(k, w) [(k)*(w) +: (w)]

package cc_waypoint_bank_loader_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int NSLOTS_DEF = 8;
    localparam int SEL_W_DEF  = 3;

    typedef enum logic [1:0] {
        WP_IDLE = 2'd0,   // bank empty
        WP_LOAD = 2'd1,   // partially loaded, still accepting
        WP_RUN  = 2'd2,   // route executing, select walks the slots
        WP_DONE = 2'd3    // last loaded waypoint reached
    } wpState_t;
endpackage

// File: rtl/cc_waypoint_bank_loader_if.sv
// Handshake / slot bus bundle of the waypoint bank loader.
//  master : write source + navigation controller + mux consumer (drives inputs)
//  slave  : the loader itself
interface cc_waypoint_bank_loader_if
    import cc_waypoint_bank_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSLOTS = NSLOTS_DEF,
    parameter int SEL_W  = SEL_W_DEF
);
    logic                     CC_WPLOAD_clear_In;
    logic                     CC_WPLOAD_wrValid_In;
    logic                     CC_WPLOAD_wrReady_Out;
    logic                     CC_WPLOAD_wrLast_In;
    logic [DATA_W-1:0]        CC_WPLOAD_wrX_InBus;
    logic [DATA_W-1:0]        CC_WPLOAD_wrY_InBus;
    logic [DATA_W-1:0]        CC_WPLOAD_wrZ_InBus;
    logic                     CC_WPLOAD_advance_In;
    logic [NSLOTS*DATA_W-1:0] CC_WPLOAD_slotX_OutBus;
    logic [NSLOTS*DATA_W-1:0] CC_WPLOAD_slotY_OutBus;
    logic [NSLOTS*DATA_W-1:0] CC_WPLOAD_slotZ_OutBus;
    logic [SEL_W-1:0]         CC_WPLOAD_select_OutBus;
    logic [SEL_W:0]           CC_WPLOAD_count_OutBus;
    logic                     CC_WPLOAD_running_Out;
    logic                     CC_WPLOAD_done_Out;

    modport slave (
        input  CC_WPLOAD_clear_In, CC_WPLOAD_wrValid_In, CC_WPLOAD_wrLast_In,
               CC_WPLOAD_wrX_InBus, CC_WPLOAD_wrY_InBus, CC_WPLOAD_wrZ_InBus,
               CC_WPLOAD_advance_In,
        output CC_WPLOAD_wrReady_Out, CC_WPLOAD_slotX_OutBus, CC_WPLOAD_slotY_OutBus,
               CC_WPLOAD_slotZ_OutBus, CC_WPLOAD_select_OutBus, CC_WPLOAD_count_OutBus,
               CC_WPLOAD_running_Out, CC_WPLOAD_done_Out
    );

    modport master (
        output CC_WPLOAD_clear_In, CC_WPLOAD_wrValid_In, CC_WPLOAD_wrLast_In,
               CC_WPLOAD_wrX_InBus, CC_WPLOAD_wrY_InBus, CC_WPLOAD_wrZ_InBus,
               CC_WPLOAD_advance_In,
        input  CC_WPLOAD_wrReady_Out, CC_WPLOAD_slotX_OutBus, CC_WPLOAD_slotY_OutBus,
               CC_WPLOAD_slotZ_OutBus, CC_WPLOAD_select_OutBus, CC_WPLOAD_count_OutBus,
               CC_WPLOAD_running_Out, CC_WPLOAD_done_Out
    );
endinterface

// File: rtl/cc_waypoint_slot_reg.sv
// One waypoint slot: x/y/z register triple.
//  clk, rst      clock, async active-high reset (zeroes the slot)
//  clr           sync clear, wins over we
//  we            load dX/dY/dZ
//  qX/qY/qZ      stored coordinates
module cc_waypoint_slot_reg
    import cc_waypoint_bank_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] dX,
    input  logic [DATA_W-1:0] dY,
    input  logic [DATA_W-1:0] dZ,
    output logic [DATA_W-1:0] qX,
    output logic [DATA_W-1:0] qY,
    output logic [DATA_W-1:0] qZ
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qX <= '0;
            qY <= '0;
            qZ <= '0;
        end else if (clr) begin
            qX <= '0;
            qY <= '0;
            qZ <= '0;
        end else if (we) begin
            qX <= dX;
            qY <= dY;
            qZ <= dZ;
        end
    end
endmodule

// File: rtl/cc_waypoint_bank_loader.sv
// Waypoint bank loader: write side of the 8:1 x/y/z waypoint mux.
//  CC_WPLOAD_CLOCK_50      clock, rising edge
//  CC_WPLOAD_RESET_InHigh  async active-high reset
//  wp (slave)              write handshake (valid/ready/last + x/y/z), advance pulse,
//                          packed slot buses, mux select, count, running, done
// Triples fill slots in order; the write pointer is the count itself, so it
// cannot wrap. A last-flagged write or the eighth write starts the route.
module cc_waypoint_bank_loader
    import cc_waypoint_bank_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NSLOTS = NSLOTS_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic                      CC_WPLOAD_CLOCK_50,
    input  logic                      CC_WPLOAD_RESET_InHigh,
    cc_waypoint_bank_loader_if.slave  wp
);
    logic clk, rst;
    assign clk = CC_WPLOAD_CLOCK_50;
    assign rst = CC_WPLOAD_RESET_InHigh;

    wpState_t         state, stateNxt;
    logic [SEL_W:0]   count, countNxt;
    logic [SEL_W-1:0] select, selectNxt;
    logic             running, runningNxt;
    logic             done, doneNxt;
    logic             clear, accept, wrReady;

    assign clear   = wp.CC_WPLOAD_clear_In;
    // ready is suppressed during reset and on a clear cycle so a clear can never
    // coincide with a stored write
    assign wrReady = (state == WP_IDLE || state == WP_LOAD) && !clear && !rst;
    assign accept  = wp.CC_WPLOAD_wrValid_In && wrReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WP_IDLE;
            count   <= '0;
            select  <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= stateNxt;
            count   <= countNxt;
            select  <= selectNxt;
            running <= runningNxt;
            done    <= doneNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        countNxt   = count;
        selectNxt  = select;
        runningNxt = running;
        doneNxt    = done;
        if (clear) begin
            stateNxt   = WP_IDLE;
            countNxt   = '0;
            selectNxt  = '0;
            runningNxt = 1'b0;
            doneNxt    = 1'b0;
        end else begin
            unique case (state)
                WP_IDLE, WP_LOAD: begin
                    if (accept) begin
                        countNxt = count + (SEL_W+1)'(1);
                        if (wp.CC_WPLOAD_wrLast_In || count == (SEL_W+1)'(NSLOTS-1)) begin
                            stateNxt   = WP_RUN;
                            selectNxt  = '0;
                            runningNxt = 1'b1;
                        end else begin
                            stateNxt = WP_LOAD;
                        end
                    end
                end
                WP_RUN: begin
                    if (wp.CC_WPLOAD_advance_In) begin
                        // RUN is only entered with count >= 1, so count-1 is safe
                        if ({1'b0, select} == count - (SEL_W+1)'(1)) begin
                            stateNxt   = WP_DONE;
                            runningNxt = 1'b0;
                            doneNxt    = 1'b1;
                        end else begin
                            selectNxt = select + SEL_W'(1);
                        end
                    end
                end
                WP_DONE: ;
                default: stateNxt = WP_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NSLOTS; k++) begin : gSlot
        logic [DATA_W-1:0] qX, qY, qZ;
        logic              we;
        assign we = accept && (count == (SEL_W+1)'(k));

        cc_waypoint_slot_reg #(.DATA_W(DATA_W)) uSlot (
            .clk (clk),
            .rst (rst),
            .clr (clear),
            .we  (we),
            .dX  (wp.CC_WPLOAD_wrX_InBus),
            .dY  (wp.CC_WPLOAD_wrY_InBus),
            .dZ  (wp.CC_WPLOAD_wrZ_InBus),
            .qX  (qX),
            .qY  (qY),
            .qZ  (qZ)
        );

        assign wp.CC_WPLOAD_slotX_OutBus `CC_WP_SLOT(k, DATA_W) = qX;
        assign wp.CC_WPLOAD_slotY_OutBus `CC_WP_SLOT(k, DATA_W) = qY;
        assign wp.CC_WPLOAD_slotZ_OutBus `CC_WP_SLOT(k, DATA_W) = qZ;
    end

    assign wp.CC_WPLOAD_wrReady_Out   = wrReady;
    assign wp.CC_WPLOAD_select_OutBus = select;
    assign wp.CC_WPLOAD_count_OutBus  = count;
    assign wp.CC_WPLOAD_running_Out   = running;
    assign wp.CC_WPLOAD_done_Out      = done;
endmodule

// File: tb/tb_cc_waypoint_bank_loader.sv
// Directed bench for cc_waypoint_bank_loader: reset, load, route walk,
// auto-run on full bank, clear priority, ignored advance pulses.
module tb_cc_waypoint_bank_loader;
    import cc_waypoint_bank_loader_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    cc_waypoint_bank_loader_if #(.DATA_W(DW), .NSLOTS(8), .SEL_W(3)) wp ();

    cc_waypoint_bank_loader #(.DATA_W(DW), .NSLOTS(8), .SEL_W(3)) dut (
        .CC_WPLOAD_CLOCK_50     (clk),
        .CC_WPLOAD_RESET_InHigh (rst),
        .wp                     (wp.slave)
    );

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] slotOf(input logic [8*DW-1:0] bus, input int k);
        return bus[k*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendTriple(input logic [DW-1:0] x, y, z, input logic last);
        wp.CC_WPLOAD_wrValid_In = 1'b1;
        wp.CC_WPLOAD_wrLast_In  = last;
        wp.CC_WPLOAD_wrX_InBus  = x;
        wp.CC_WPLOAD_wrY_InBus  = y;
        wp.CC_WPLOAD_wrZ_InBus  = z;
        step();
        wp.CC_WPLOAD_wrValid_In = 1'b0;
        wp.CC_WPLOAD_wrLast_In  = 1'b0;
    endtask

    task automatic pulseAdvance();
        wp.CC_WPLOAD_advance_In = 1'b1;
        step();
        wp.CC_WPLOAD_advance_In = 1'b0;
    endtask

    task automatic pulseClear();
        wp.CC_WPLOAD_clear_In = 1'b1;
        step();
        wp.CC_WPLOAD_clear_In = 1'b0;
    endtask

    initial begin
        logic [8*DW-1:0] expX;
        wp.CC_WPLOAD_clear_In   = 1'b0;
        wp.CC_WPLOAD_wrValid_In = 1'b0;
        wp.CC_WPLOAD_wrLast_In  = 1'b0;
        wp.CC_WPLOAD_wrX_InBus  = '0;
        wp.CC_WPLOAD_wrY_InBus  = '0;
        wp.CC_WPLOAD_wrZ_InBus  = '0;
        wp.CC_WPLOAD_advance_In = 1'b0;

        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rstReady", wp.CC_WPLOAD_wrReady_Out, 0);
        chk("rstCount", wp.CC_WPLOAD_count_OutBus, 0);
        rst = 1'b0;
        step();
        chk("idleReady", wp.CC_WPLOAD_wrReady_Out, 1);

        // 1: reset in the middle of a load
        sendTriple(32'd11, 32'd12, 32'd13, 1'b0);
        sendTriple(32'd21, 32'd22, 32'd23, 1'b0);
        sendTriple(32'd31, 32'd32, 32'd33, 1'b0);
        chk("midCount", wp.CC_WPLOAD_count_OutBus, 3);
        chk("midSlot2X", slotOf(wp.CC_WPLOAD_slotX_OutBus, 2), 32'd31);
        rst = 1'b1;
        #1;
        chk("asyncCount", wp.CC_WPLOAD_count_OutBus, 0);
        chk("asyncSlotX", wp.CC_WPLOAD_slotX_OutBus, 0);
        chk("asyncSlotZ", wp.CC_WPLOAD_slotZ_OutBus, 0);
        chk("asyncReady", wp.CC_WPLOAD_wrReady_Out, 0);
        chk("asyncRun", wp.CC_WPLOAD_running_Out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("relReady", wp.CC_WPLOAD_wrReady_Out, 1);

        // 2: three-waypoint route
        sendTriple(32'd1, 32'd2, 32'd3, 1'b0);
        chk("ld1Count", wp.CC_WPLOAD_count_OutBus, 1);
        chk("ld1Run", wp.CC_WPLOAD_running_Out, 0);
        sendTriple(32'd4, 32'd5, 32'd6, 1'b0);
        sendTriple(32'd7, 32'd8, 32'd9, 1'b1);
        chk("rtCount", wp.CC_WPLOAD_count_OutBus, 3);
        chk("rtRun", wp.CC_WPLOAD_running_Out, 1);
        chk("rtSel", wp.CC_WPLOAD_select_OutBus, 0);
        chk("rtReady", wp.CC_WPLOAD_wrReady_Out, 0);
        chk("rtSlot2X", slotOf(wp.CC_WPLOAD_slotX_OutBus, 2), 32'd7);
        chk("rtSlot2Y", slotOf(wp.CC_WPLOAD_slotY_OutBus, 2), 32'd8);
        chk("rtSlot2Z", slotOf(wp.CC_WPLOAD_slotZ_OutBus, 2), 32'd9);
        expX = '0;
        expX[31:0]  = 32'd1;
        expX[63:32] = 32'd4;
        expX[95:64] = 32'd7;
        chk("rtBusX", wp.CC_WPLOAD_slotX_OutBus, expX);
        chk("rtHighY", wp.CC_WPLOAD_slotY_OutBus[8*DW-1:3*DW], 0);
        chk("rtHighZ", wp.CC_WPLOAD_slotZ_OutBus[8*DW-1:3*DW], 0);

        // 3: walk the route
        pulseAdvance();
        chk("adv1Sel", wp.CC_WPLOAD_select_OutBus, 1);
        pulseAdvance();
        chk("adv2Sel", wp.CC_WPLOAD_select_OutBus, 2);
        chk("adv2Done", wp.CC_WPLOAD_done_Out, 0);
        pulseAdvance();
        chk("adv3Done", wp.CC_WPLOAD_done_Out, 1);
        chk("adv3Sel", wp.CC_WPLOAD_select_OutBus, 2);
        chk("adv3Run", wp.CC_WPLOAD_running_Out, 0);
        pulseAdvance();
        chk("doneHoldSel", wp.CC_WPLOAD_select_OutBus, 2);
        chk("doneHoldDone", wp.CC_WPLOAD_done_Out, 1);
        chk("doneReady", wp.CC_WPLOAD_wrReady_Out, 0);

        // 4: full bank auto-runs, extra write is held off
        pulseClear();
        chk("clrCount", wp.CC_WPLOAD_count_OutBus, 0);
        chk("clrDone", wp.CC_WPLOAD_done_Out, 0);
        chk("clrSlotX", wp.CC_WPLOAD_slotX_OutBus, 0);
        for (int k = 0; k < 7; k++)
            sendTriple(32'(10 + k), 32'(20 + k), 32'(30 + k), 1'b0);
        chk("fill7Count", wp.CC_WPLOAD_count_OutBus, 7);
        chk("fill7Run", wp.CC_WPLOAD_running_Out, 0);
        sendTriple(32'd17, 32'd27, 32'd37, 1'b0);
        chk("fill8Count", wp.CC_WPLOAD_count_OutBus, 8);
        chk("fill8Run", wp.CC_WPLOAD_running_Out, 1);
        chk("fill8Ready", wp.CC_WPLOAD_wrReady_Out, 0);
        chk("fill8Slot7Z", slotOf(wp.CC_WPLOAD_slotZ_OutBus, 7), 32'd37);
        chk("fill8Slot0X", slotOf(wp.CC_WPLOAD_slotX_OutBus, 0), 32'd10);
        wp.CC_WPLOAD_wrValid_In = 1'b1;
        wp.CC_WPLOAD_wrX_InBus  = 32'd99;
        #1;
        chk("ninthReady", wp.CC_WPLOAD_wrReady_Out, 0);
        step();
        step();
        wp.CC_WPLOAD_wrValid_In = 1'b0;
        chk("ninthCount", wp.CC_WPLOAD_count_OutBus, 8);
        chk("ninthSlot7X", slotOf(wp.CC_WPLOAD_slotX_OutBus, 7), 32'd17);
        chk("ninthSlot0X", slotOf(wp.CC_WPLOAD_slotX_OutBus, 0), 32'd10);
        for (int k = 0; k < 7; k++) pulseAdvance();
        chk("walk7Sel", wp.CC_WPLOAD_select_OutBus, 7);
        chk("walk7Run", wp.CC_WPLOAD_running_Out, 1);
        pulseAdvance();
        chk("walk8Done", wp.CC_WPLOAD_done_Out, 1);
        chk("walk8Sel", wp.CC_WPLOAD_select_OutBus, 7);

        // 5: clear beats a simultaneous write
        pulseClear();
        wp.CC_WPLOAD_clear_In   = 1'b1;
        wp.CC_WPLOAD_wrValid_In = 1'b1;
        wp.CC_WPLOAD_wrX_InBus  = 32'd55;
        #1;
        chk("clrWrReady", wp.CC_WPLOAD_wrReady_Out, 0);
        step();
        wp.CC_WPLOAD_clear_In   = 1'b0;
        wp.CC_WPLOAD_wrValid_In = 1'b0;
        chk("clrWrCount", wp.CC_WPLOAD_count_OutBus, 0);
        chk("clrWrSlotX", wp.CC_WPLOAD_slotX_OutBus, 0);
        #1;
        chk("clrWrReadyNext", wp.CC_WPLOAD_wrReady_Out, 1);

        // 6: advance ignored while loading; clear beats advance in RUN
        pulseAdvance();
        chk("idleAdvSel", wp.CC_WPLOAD_select_OutBus, 0);
        chk("idleAdvRun", wp.CC_WPLOAD_running_Out, 0);
        chk("idleAdvReady", wp.CC_WPLOAD_wrReady_Out, 1);
        sendTriple(32'hA, 32'hB, 32'hC, 1'b0);
        pulseAdvance();
        chk("loadAdvSel", wp.CC_WPLOAD_select_OutBus, 0);
        chk("loadAdvCount", wp.CC_WPLOAD_count_OutBus, 1);
        chk("loadAdvRun", wp.CC_WPLOAD_running_Out, 0);
        sendTriple(32'hD, 32'hE, 32'hF, 1'b1);
        chk("run2Run", wp.CC_WPLOAD_running_Out, 1);
        pulseAdvance();
        chk("run2Sel", wp.CC_WPLOAD_select_OutBus, 1);
        wp.CC_WPLOAD_clear_In   = 1'b1;
        wp.CC_WPLOAD_advance_In = 1'b1;
        step();
        wp.CC_WPLOAD_clear_In   = 1'b0;
        wp.CC_WPLOAD_advance_In = 1'b0;
        chk("clrAdvSel", wp.CC_WPLOAD_select_OutBus, 0);
        chk("clrAdvDone", wp.CC_WPLOAD_done_Out, 0);
        chk("clrAdvRun", wp.CC_WPLOAD_running_Out, 0);
        chk("clrAdvCount", wp.CC_WPLOAD_count_OutBus, 0);
        #1;
        chk("clrAdvReady", wp.CC_WPLOAD_wrReady_Out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
